// File: rtl/adc_pkg.sv
// Shared definitions for the ADC SPI sampler slice.
//   adc_state_e : sampler FSM encoding (IDLE, CS_SETUP, SHIFT, QUIET)
//   ADC_*       : default frame geometry and timing
//   cnt_w()     : counter width helper, never narrower than one bit
package adc_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CS_SETUP = 2'd1,
    SHIFT    = 2'd2,
    QUIET    = 2'd3
  } adc_state_e;

  localparam int unsigned ADC_CLK_DIV    = 4;
  localparam int unsigned ADC_FRAME_BITS = 16;
  localparam int unsigned ADC_DATA_BITS  = 12;
  localparam int unsigned ADC_QUIET_CYC  = 8;

  // Width of a counter that must hold values 0..n-1.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adc_spi_sampler_if.sv
// Bus bundle between the sampler, the serial ADC and the capture stage.
//   adc_cs_n   : chip select, active low          (master -> ADC)
//   adc_sclk   : serial clock, idles high         (master -> ADC)
//   adc_sdo    : serial data, MSB first           (ADC -> master)
//   adc_data   : last good conversion result      (master -> capture)
//   adc_valid  : 1-cycle strobe, adc_data updated (master -> capture)
//   frame_err  : 1-cycle strobe, frame rejected   (master -> capture)
// Handshake: the result side is valid-only. adc_valid is high for exactly one
// clk cycle and adc_data is stable from that cycle until the next adc_valid;
// there is no ready, so the consumer must accept the value in that cycle.
// adc_valid and frame_err are never high together.
interface adc_spi_sampler_if
  import adc_pkg::*;
#(
  parameter int unsigned DATA_BITS = ADC_DATA_BITS
);
  logic                 adc_cs_n;
  logic                 adc_sclk;
  logic                 adc_sdo;
  logic [DATA_BITS-1:0] adc_data;
  logic                 adc_valid;
  logic                 frame_err;

  modport master (
    output adc_cs_n, adc_sclk, adc_data, adc_valid, frame_err,
    input  adc_sdo
  );

  modport slave (
    input  adc_cs_n, adc_sclk, adc_data, adc_valid, frame_err,
    output adc_sdo
  );
endinterface

// File: rtl/adc_sclk_divider.sv
// SCLK half-period generator for the ADC sampler.
//   clk, rst_n : system clock, async active-low reset
//   en_i       : run the divider; when low SCLK is parked high
//   load_i     : restart at the beginning of a low phase (frame start)
//   sclk_o     : registered SCLK level
//   rise_o     : high in the last cycle of a low phase (SCLK goes 1 next)
//   fall_o     : high in the last cycle of a high phase (SCLK goes 0 next)
module adc_sclk_divider
  import adc_pkg::*;
#(
  parameter int unsigned CLK_DIV = ADC_CLK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic load_i,
  output logic sclk_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned     CW   = cnt_w(CLK_DIV);
  localparam logic [CW-1:0]   LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          lvl_q, lvl_d;

  always_comb begin
    cnt_d = cnt_q;
    lvl_d = lvl_q;
    if (load_i) begin
      cnt_d = '0;
      lvl_d = 1'b0;
    end else if (en_i) begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
        lvl_d = ~lvl_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = '0;
      lvl_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      lvl_q <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      lvl_q <= lvl_d;
    end
  end

  // Strobes come straight from registers so the top can use them when
  // computing its next state without forming a loop through en_i.
  assign sclk_o = lvl_q;
  assign rise_o = ~lvl_q & (cnt_q == LAST);
  assign fall_o =  lvl_q & (cnt_q == LAST);

endmodule

// File: rtl/adc_spi_sampler.sv
// SPI master for the 12-bit serial ADC on the buck output-voltage sense path.
// One conversion is framed per start request (PWM trigger or internal period
// timer); the result is presented on the bus as adc_data + adc_valid.
//   clk, rst_n   : system clock, async active-low reset
//   enable       : 1 = accept start requests (also gates the period timer)
//   trigger      : 1-cycle start request
//   bus          : SPI pins and result strobes (master modport)
//   trigger_miss : 1-cycle strobe, start request dropped because not IDLE
//   busy         : 1 whenever the FSM is not IDLE
//   dbg_state_o  : current FSM state
module adc_spi_sampler
  import adc_pkg::*;
#(
  parameter int unsigned CLK_DIV     = ADC_CLK_DIV,
  parameter int unsigned FRAME_BITS  = ADC_FRAME_BITS,
  parameter int unsigned DATA_BITS   = ADC_DATA_BITS,
  parameter int unsigned QUIET_CYC   = ADC_QUIET_CYC,
  parameter int unsigned AUTO_PERIOD = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               trigger,
  adc_spi_sampler_if.master  bus,
  output logic               trigger_miss,
  output logic               busy,
  output adc_state_e         dbg_state_o
);

  // One counter serves both CS_SETUP and QUIET, so size it for the longer.
  localparam int unsigned PW = cnt_w((QUIET_CYC > CLK_DIV) ? QUIET_CYC : CLK_DIV);
  localparam int unsigned BW = cnt_w(FRAME_BITS);

  adc_state_e              state_q, state_d;
  logic [PW-1:0]           phase_q, phase_d;
  logic [BW-1:0]           bit_q, bit_d;
  logic [FRAME_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]    data_q, data_d;
  logic                    cs_n_q, cs_n_d;
  logic                    valid_q, valid_d;
  logic                    ferr_q, ferr_d;
  logic                    miss_q, miss_d;
  logic                    busy_q, busy_d;

  logic start;
  logic timer_expire;
  logic div_en, div_load;
  logic sclk, sclk_rise, sclk_fall;

  // Period timer: free-runs while enabled, independent of the FSM state.
  generate
    if (AUTO_PERIOD == 0) begin : g_no_timer
      assign timer_expire = 1'b0;
    end else begin : g_timer
      localparam int unsigned TW = cnt_w(AUTO_PERIOD);
      logic [TW-1:0] timer_q, timer_d;

      always_comb begin
        timer_expire = enable && (timer_q == TW'(AUTO_PERIOD - 1));
        timer_d      = timer_q;
        if (enable) begin
          timer_d = timer_expire ? '0 : timer_q + TW'(1);
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) timer_q <= '0;
        else        timer_q <= timer_d;
      end
    end
  endgenerate

  // Trigger and timer landing together collapse into one start.
  assign start = enable & (trigger | timer_expire);

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    miss_d  = start & (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CS_SETUP;
          phase_d = '0;
        end
      end
      CS_SETUP: begin
        if (phase_q == PW'(CLK_DIV - 1)) begin
          state_d = SHIFT;
          bit_d   = '0;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      SHIFT: begin
        if (sclk_rise) begin
          shift_d = {shift_q[FRAME_BITS-2:0], bus.adc_sdo};
        end
        // The end of a high phase closes a bit; the last one closes the frame.
        if (sclk_fall) begin
          if (bit_q == BW'(FRAME_BITS - 1)) begin
            state_d = QUIET;
            phase_d = '0;
            if (shift_q[FRAME_BITS-1:DATA_BITS] == '0) begin
              valid_d = 1'b1;
              data_d  = shift_q[DATA_BITS-1:0];
            end else begin
              ferr_d  = 1'b1;
            end
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      QUIET: begin
        if (phase_q == PW'(QUIET_CYC - 1)) begin
          state_d = IDLE;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they change together
    // with the state register and never glitch.
    cs_n_d   = ~((state_d == CS_SETUP) || (state_d == SHIFT));
    busy_d   = (state_d != IDLE);
    div_en   = (state_d == SHIFT);
    div_load = (state_q != SHIFT) && (state_d == SHIFT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      phase_q <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      cs_n_q  <= 1'b1;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      miss_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      cs_n_q  <= cs_n_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      miss_q  <= miss_d;
      busy_q  <= busy_d;
    end
  end

  adc_sclk_divider #(
    .CLK_DIV (CLK_DIV)
  ) u_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (div_en),
    .load_i (div_load),
    .sclk_o (sclk),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  assign bus.adc_cs_n  = cs_n_q;
  assign bus.adc_sclk  = sclk;
  assign bus.adc_data  = data_q;
  assign bus.adc_valid = valid_q;
  assign bus.frame_err = ferr_q;
  assign trigger_miss  = miss_q;
  assign busy          = busy_q;
  assign dbg_state_o   = state_q;

endmodule
